channel_cmd_arbiter: RTL and testbench

- Shares the single command port of the channel processor (address/data/valid with ack) between NREQ requesters, e.g. UART command decoder, button/switch sequencer and test pattern loader.
- Grants one requester at a time using round-robin priority.
- Holds the selected address/data and valid until the processor acknowledges or a timeout expires, then returns done or error to the granted requester.

---
 rtl/channel_arb_pkg.sv | 30 +++
 rtl/rr_priority_picker.sv | 34 +++
 rtl/channel_cmd_arbiter.sv | 145 ++++++++++++++
 tb/tb_channel_cmd_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_arb_pkg.sv
// Shared types and constants for the channel command arbiter.
// Holds the FSM encoding, the clog2 helper and the default command widths.
package channel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } arb_state_e;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 4;

    // Ceiling log2, never returns less than 1 so it can size index fields directly.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: finds the first set request bit at or
// after the pointer, wrapping modulo NREQ.
module rr_priority_picker
    import channel_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] pointer,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W:0] k;

    // Scan from the farthest offset down so the closest candidate is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = {1'b0, pointer} + (IDX_W + 1)'(i);
            if (k >= (IDX_W + 1)'(NREQ)) begin
                k = k - (IDX_W + 1)'(NREQ);
            end
            if (req[k[IDX_W-1:0]]) begin
                found = 1'b1;
                index = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/channel_cmd_arbiter.sv
// Round-robin arbiter sharing the channel processor command port between
// NREQ requesters, with ack/timeout completion reported back as done/err pulses.
module channel_cmd_arbiter
    import channel_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err,
    output logic                     cp_valid,
    output logic [ADDR_W-1:0]        cp_address,
    output logic [DATA_W-1:0]        cp_data,
    input  logic                     cp_ack,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy
);

    localparam int IDX_W = clog2(NREQ);
    localparam int CNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cp_valid_q, cp_valid_d;
    logic [ADDR_W-1:0]   cp_addr_q, cp_addr_d;
    logic [DATA_W-1:0]   cp_data_q, cp_data_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [NREQ-1:0]     err_q, err_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    logic [ADDR_W-1:0]   addr_arr [NREQ];
    logic [DATA_W-1:0]   data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_priority_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .pointer (ptr_q),
        .found   (pick_found),
        .index   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        cp_valid_d = cp_valid_q;
        cp_addr_d  = cp_addr_q;
        cp_data_d  = cp_data_q;
        done_d     = '0;
        err_d      = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    cp_addr_d  = addr_arr[pick_idx];
                    cp_data_d  = data_arr[pick_idx];
                    cp_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Ack is tested first so it wins over a timeout expiring in the same cycle.
                if (cp_ack) begin
                    cp_valid_d      = 1'b0;
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    cp_valid_d     = 1'b0;
                    err_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ptr_d   = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                cp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            cp_valid_q <= 1'b0;
            cp_addr_q  <= '0;
            cp_data_q  <= '0;
            done_q     <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            cp_valid_q <= cp_valid_d;
            cp_addr_q  <= cp_addr_d;
            cp_data_q  <= cp_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign req_done   = done_q;
    assign req_err    = err_q;
    assign cp_valid   = cp_valid_q;
    assign cp_address = cp_addr_q;
    assign cp_data    = cp_data_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_channel_cmd_arbiter.sv
// Directed bench for channel_cmd_arbiter: single command, round-robin order,
// timeout, ack/timeout tie, reset mid-command and spurious ack / dropped request.
module tb_channel_cmd_arbiter;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_done;
    logic [NREQ-1:0]        req_err;
    logic                   cp_valid;
    logic [ADDR_W-1:0]      cp_address;
    logic [DATA_W-1:0]      cp_data;
    logic                   cp_ack;
    logic [1:0]             grant_id;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_cmd_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_done   (req_done),
        .req_err    (req_err),
        .cp_valid   (cp_valid),
        .cp_address (cp_address),
        .cp_data    (cp_data),
        .cp_ack     (cp_ack),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one command from IDLE with req already driven; ack is raised after d extra WAIT_ACK cycles.
    task automatic do_cmd(input string tag, input int exp_g, input logic [3:0] exp_a,
                          input logic [3:0] exp_d, input int d);
        logic [NREQ-1:0] exp_onehot;
        exp_onehot        = '0;
        exp_onehot[exp_g] = 1'b1;
        tick();
        check_eq({tag, "_valid"}, 32'(cp_valid), 32'd1);
        check_eq({tag, "_grant"}, 32'(grant_id), 32'(exp_g));
        check_eq({tag, "_addr"}, 32'(cp_address), 32'(exp_a));
        check_eq({tag, "_data"}, 32'(cp_data), 32'(exp_d));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < d; i++) begin
            tick();
            check_eq({tag, "_hold_valid"}, 32'(cp_valid), 32'd1);
            check_eq({tag, "_hold_addr"}, 32'(cp_address), 32'(exp_a));
        end
        cp_ack = 1'b1;
        tick();
        check_eq({tag, "_done"}, 32'(req_done), 32'(exp_onehot));
        check_eq({tag, "_noerr"}, 32'(req_err), 32'd0);
        check_eq({tag, "_valid_low"}, 32'(cp_valid), 32'd0);
        cp_ack = 1'b0;
        tick();
        check_eq({tag, "_done_clr"}, 32'(req_done), 32'd0);
        check_eq({tag, "_gap_low"}, 32'(cp_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        $display("txn %s: grant=%0d addr=%0h data=%0h", tag, exp_g, exp_a, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        cp_ack   = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 32'(cp_valid), 32'd0);
        check_eq("rst_addr", 32'(cp_address), 32'd0);
        check_eq("rst_data", 32'(cp_data), 32'd0);
        check_eq("rst_done", 32'(req_done), 32'd0);
        check_eq("rst_err", 32'(req_err), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // Single request from requester 2
        req      = 4'b0100;
        req_addr = 16'h0200;
        req_data = 16'h0100;
        do_cmd("single", 2, 4'h2, 4'h1, 1);
        req = '0;
        tick();
        check_eq("single_grant_kept", 32'(grant_id), 32'd2);
        check_eq("single_no_regrant", 32'(cp_valid), 32'd0);

        // Round-robin from a fresh pointer
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        req      = 4'b1111;
        req_addr = 16'hBA98;
        req_data = 16'h4321;
        do_cmd("rr0", 0, 4'h8, 4'h1, 0);
        do_cmd("rr1", 1, 4'h9, 4'h2, 0);
        do_cmd("rr2", 2, 4'hA, 4'h3, 0);
        do_cmd("rr3", 3, 4'hB, 4'h4, 0);
        do_cmd("rr4", 0, 4'h8, 4'h1, 0);
        req = '0;

        // Timeout: pointer is 1, only requester 0 asks
        req      = 4'b0001;
        req_addr = 16'h0005;
        req_data = 16'h0006;
        tick();
        check_eq("to_valid", 32'(cp_valid), 32'd1);
        check_eq("to_grant", 32'(grant_id), 32'd0);
        check_eq("to_addr", 32'(cp_address), 32'd5);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check_eq("to_hold", 32'(cp_valid), 32'd1);
        end
        tick();
        check_eq("to_valid_low", 32'(cp_valid), 32'd0);
        check_eq("to_err", 32'(req_err), 32'b0001);
        check_eq("to_nodone", 32'(req_done), 32'd0);
        req = '0;
        tick();
        check_eq("to_err_clr", 32'(req_err), 32'd0);
        check_eq("to_idle", 32'(busy), 32'd0);
        $display("txn timeout: grant=0 err pulsed");
        req      = 4'b1000;
        req_addr = 16'h7000;
        req_data = 16'h9000;
        do_cmd("after_to", 3, 4'h7, 4'h9, 2);
        req = '0;

        // Ack in the exact expiry cycle
        req      = 4'b0001;
        req_addr = 16'h000C;
        req_data = 16'h000D;
        tick();
        check_eq("tie_grant", 32'(grant_id), 32'd0);
        repeat (TIMEOUT - 1) tick();
        check_eq("tie_still_valid", 32'(cp_valid), 32'd1);
        cp_ack = 1'b1;
        tick();
        check_eq("tie_done", 32'(req_done), 32'b0001);
        check_eq("tie_noerr", 32'(req_err), 32'd0);
        cp_ack = 1'b0;
        req    = '0;
        tick();
        $display("txn tie: grant=0 done pulsed");

        // Reset while WAIT_ACK
        req      = 4'b0100;
        req_addr = 16'h0E00;
        req_data = 16'h0F00;
        tick();
        check_eq("mid_grant", 32'(grant_id), 32'd2);
        tick();
        check_eq("mid_valid", 32'(cp_valid), 32'd1);
        rst = 1'b0;
        req = '0;
        #1;
        check_eq("mid_rst_valid", 32'(cp_valid), 32'd0);
        check_eq("mid_rst_grant", 32'(grant_id), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_addr", 32'(cp_address), 32'd0);
        tick();
        check_eq("mid_rst_nodone", 32'(req_done), 32'd0);
        check_eq("mid_rst_noerr", 32'(req_err), 32'd0);
        rst      = 1'b1;
        req      = 4'b1001;
        req_addr = 16'h3001;
        req_data = 16'h5002;
        do_cmd("ptr_reset", 0, 4'h1, 4'h2, 0);
        req      = 4'b0010;
        req_addr = 16'h0040;
        req_data = 16'h0060;
        do_cmd("post_reset", 1, 4'h4, 4'h6, 0);
        req = '0;

        // Spurious ack while idle, then a request dropped mid-command
        cp_ack = 1'b1;
        tick();
        check_eq("spur_done", 32'(req_done), 32'd0);
        check_eq("spur_err", 32'(req_err), 32'd0);
        check_eq("spur_valid", 32'(cp_valid), 32'd0);
        tick();
        check_eq("spur_done2", 32'(req_done), 32'd0);
        check_eq("spur_busy", 32'(busy), 32'd0);
        cp_ack   = 1'b0;
        req      = 4'b0100;
        req_addr = 16'h0300;
        req_data = 16'h0800;
        tick();
        check_eq("drop_grant", 32'(grant_id), 32'd2);
        check_eq("drop_addr", 32'(cp_address), 32'd3);
        req = '0;
        tick();
        tick();
        check_eq("drop_held", 32'(cp_valid), 32'd1);
        cp_ack = 1'b1;
        tick();
        check_eq("drop_done", 32'(req_done), 32'b0100);
        check_eq("drop_noerr", 32'(req_err), 32'd0);
        cp_ack = 1'b0;
        tick();
        check_eq("drop_done_clr", 32'(req_done), 32'd0);
        tick();
        check_eq("drop_no_regrant", 32'(cp_valid), 32'd0);
        check_eq("drop_idle", 32'(busy), 32'd0);
        $display("txn dropped: grant=2 done pulsed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
